// File: rtl/wvb_reader_arb_pkg.sv
// Shared definitions for the waveform-buffer reader arbiter.
//   N_CHAN_DEFAULT : default number of arbitrated waveform buffers
//   IDX_W          : channel index width driven to the read controller
//   LEN_W          : DPRAM length width (common with the read controller)
//   state_e        : reader FSM states
package wvb_reader_arb_pkg;

  localparam int unsigned N_CHAN_DEFAULT = 24;
  localparam int unsigned IDX_W          = 8;
  localparam int unsigned LEN_W          = 16;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StHost,
    StRel
  } state_e;

endpackage

// File: rtl/wvb_rr_arb.sv
// Combinational round-robin pick: the first set bit of req, searching from ptr+1
// upwards and wrapping at NChan. Nothing is registered here.
//   req    in  NChan   request vector (one bit per channel)
//   ptr    in  IDX_W   last granted channel (must be < NChan)
//   valid  out 1       at least one request present
//   winner out IDX_W   granted channel index, zero when !valid
module wvb_rr_arb
  import wvb_reader_arb_pkg::*;
#(
  parameter int unsigned NChan = N_CHAN_DEFAULT
) (
  input  logic [NChan-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  localparam int unsigned SelW = (NChan > 1) ? $clog2(NChan) : 1;

  int unsigned cand;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    cand   = 0;
    // ptr < NChan, so ptr + i < 2*NChan and a single subtraction wraps it.
    for (int unsigned i = 1; i <= NChan; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= NChan) begin
        cand = cand - NChan;
      end
      if (!valid && req[cand[SelW-1:0]]) begin
        valid  = 1'b1;
        winner = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/wvb_reader_arb.sv
// Round-robin reader for the waveform buffers. Grants one channel holding a complete
// waveform to the read controller, hands each filled DPRAM to the host, waits for the
// host to drain it, and re-requests the same channel while the controller signals that
// the event continues in another DPRAM.
//   clk, rst            clock, asynchronous active-high reset
//   en                  readout enable, only looked at while idle
//   dpram_mode_in       0 truncate to one DPRAM, 1 extend across DPRAMs
//   wvb_not_empty       per-channel "complete waveform stored"
//   rd_ctrl_req/idx/dpram_mode   request, channel and mode to the read controller
//   rd_ctrl_ack/more/len         controller handshake, continuation flag, fill length
//   dpram_ready/dpram_len        DPRAM valid to host, latched length
//   dpram_done                   host drained the DPRAM (pulse)
//   n_evt, n_fill                wrapping event / DPRAM-fill counters
module wvb_reader_arb
  import wvb_reader_arb_pkg::*;
#(
  parameter int unsigned P_N_CHAN    = N_CHAN_DEFAULT,
  parameter int unsigned P_CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   dpram_mode_in,
  input  logic [P_N_CHAN-1:0]    wvb_not_empty,
  output logic                   rd_ctrl_req,
  output logic [IDX_W-1:0]       rd_ctrl_idx,
  output logic                   rd_ctrl_dpram_mode,
  input  logic                   rd_ctrl_ack,
  input  logic                   rd_ctrl_more,
  input  logic [LEN_W-1:0]       rd_ctrl_len,
  output logic                   dpram_ready,
  output logic [LEN_W-1:0]       dpram_len,
  input  logic                   dpram_done,
  output logic [P_CNT_WIDTH-1:0] n_evt,
  output logic [P_CNT_WIDTH-1:0] n_fill
);

  // Pointer starts at the last channel so channel 0 is searched first.
  localparam logic [IDX_W-1:0] PtrRst = IDX_W'(P_N_CHAN - 1);

  state_e                 state_q, state_d;
  logic                   req_q, req_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   mode_q, mode_d;
  logic                   ready_q, ready_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic                   more_q, more_d;
  logic [P_CNT_WIDTH-1:0] n_evt_q, n_evt_d;
  logic [P_CNT_WIDTH-1:0] n_fill_q, n_fill_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;

  logic                   arb_valid;
  logic [IDX_W-1:0]       arb_winner;

  wvb_rr_arb #(
    .NChan (P_N_CHAN)
  ) u_rr_arb (
    .req    (wvb_not_empty),
    .ptr    (ptr_q),
    .valid  (arb_valid),
    .winner (arb_winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      req_q    <= 1'b0;
      idx_q    <= '0;
      mode_q   <= 1'b0;
      ready_q  <= 1'b0;
      len_q    <= '0;
      more_q   <= 1'b0;
      n_evt_q  <= '0;
      n_fill_q <= '0;
      ptr_q    <= PtrRst;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      idx_q    <= idx_d;
      mode_q   <= mode_d;
      ready_q  <= ready_d;
      len_q    <= len_d;
      more_q   <= more_d;
      n_evt_q  <= n_evt_d;
      n_fill_q <= n_fill_d;
      ptr_q    <= ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    idx_d    = idx_q;
    mode_d   = mode_q;
    ready_d  = ready_q;
    len_d    = len_q;
    more_d   = more_q;
    n_evt_d  = n_evt_q;
    n_fill_d = n_fill_q;
    ptr_d    = ptr_q;

    unique case (state_q)
      StIdle: begin
        // Inputs are only sampled here; later changes cannot disturb a granted event.
        if (en && arb_valid) begin
          idx_d   = arb_winner;
          mode_d  = dpram_mode_in;
          req_d   = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        if (rd_ctrl_ack) begin
          len_d    = rd_ctrl_len;
          more_d   = rd_ctrl_more;
          ready_d  = 1'b1;
          n_fill_d = n_fill_q + 1'b1;
          state_d  = StHost;
        end
      end
      StHost: begin
        if (dpram_done) begin
          req_d   = 1'b0;
          ready_d = 1'b0;
          len_d   = '0;
          state_d = StRel;
        end
      end
      StRel: begin
        // Wait for the previous ack to clear so a new request never overlaps it.
        if (!rd_ctrl_ack) begin
          if (more_q) begin
            req_d   = 1'b1;
            state_d = StReq;
          end else begin
            n_evt_d = n_evt_q + 1'b1;
            ptr_d   = idx_q;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign rd_ctrl_req        = req_q;
  assign rd_ctrl_idx        = idx_q;
  assign rd_ctrl_dpram_mode = mode_q;
  assign dpram_ready        = ready_q;
  assign dpram_len          = len_q;
  assign n_evt              = n_evt_q;
  assign n_fill             = n_fill_q;

endmodule

// File: tb/tb_wvb_reader_arb.sv
module tb_wvb_reader_arb;

  localparam int N_CHAN = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              dpram_mode_in;
  logic [N_CHAN-1:0] wvb_not_empty;
  logic              rd_ctrl_req;
  logic [7:0]        rd_ctrl_idx;
  logic              rd_ctrl_dpram_mode;
  logic              rd_ctrl_ack;
  logic              rd_ctrl_more;
  logic [15:0]       rd_ctrl_len;
  logic              dpram_ready;
  logic [15:0]       dpram_len;
  logic              dpram_done;
  logic [15:0]       n_evt;
  logic [15:0]       n_fill;

  int tests = 0;
  int fails = 0;

  // Reference model state: last granted channel, event and fill totals.
  int m_ptr;
  int m_evt;
  int m_fill;

  // Read-controller model controls.
  int          ctl_delay = 0;
  int          more_left = 0;
  int          ack_base  = 0;
  logic [15:0] next_len  = 16'h0;
  int          ctl_acks;
  int          ctl_cnt;

  always #5 clk = ~clk;

  wvb_reader_arb #(
    .P_N_CHAN    (N_CHAN),
    .P_CNT_WIDTH (16)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .en                 (en),
    .dpram_mode_in      (dpram_mode_in),
    .wvb_not_empty      (wvb_not_empty),
    .rd_ctrl_req        (rd_ctrl_req),
    .rd_ctrl_idx        (rd_ctrl_idx),
    .rd_ctrl_dpram_mode (rd_ctrl_dpram_mode),
    .rd_ctrl_ack        (rd_ctrl_ack),
    .rd_ctrl_more       (rd_ctrl_more),
    .rd_ctrl_len        (rd_ctrl_len),
    .dpram_ready        (dpram_ready),
    .dpram_len          (dpram_len),
    .dpram_done         (dpram_done),
    .n_evt              (n_evt),
    .n_fill             (n_fill)
  );

  // Controller model: ack ctl_delay+1 cycles after seeing req, clear one cycle after !req.
  // The first more_left acks of an event (counted from ack_base) carry rd_ctrl_more=1.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ctrl_ack  <= 1'b0;
      rd_ctrl_more <= 1'b0;
      rd_ctrl_len  <= 16'h0;
      ctl_cnt      <= 0;
      ctl_acks     <= 0;
    end else if (!rd_ctrl_req) begin
      rd_ctrl_ack <= 1'b0;
      ctl_cnt     <= 0;
    end else if (!rd_ctrl_ack) begin
      if (ctl_cnt >= ctl_delay) begin
        rd_ctrl_ack  <= 1'b1;
        rd_ctrl_more <= ((ctl_acks - ack_base) < more_left);
        rd_ctrl_len  <= next_len;
        ctl_acks     <= ctl_acks + 1;
      end else begin
        ctl_cnt <= ctl_cnt + 1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  function automatic int rr_pick(input logic [N_CHAN-1:0] m, input int last);
    for (int i = 1; i <= N_CHAN; i++) begin
      int c = (last + i) % N_CHAN;
      if (m[c]) return c;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    rst = 1'b1; en = 1'b0; dpram_mode_in = 1'b0; wvb_not_empty = '0; dpram_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_ptr = N_CHAN - 1; m_evt = 0; m_fill = 0;
  endtask

  // Drives one full event as the host; returns observations, judging is left to callers.
  task automatic serve_event(input bit scramble, input bit drop_en, output bit ok,
                             output logic [7:0] idx0, output logic mode0,
                             output int nfill, output int bad);
    logic [15:0] evt0;
    bit          more_now;
    int          w;
    ok = 1'b1; bad = 0; nfill = 0; idx0 = '0; mode0 = 1'b0;
    evt0 = n_evt; ack_base = ctl_acks;
    next_len = 16'($urandom);
    w = 0;
    while (!rd_ctrl_req && w < 100) begin @(negedge clk); w++; end
    if (!rd_ctrl_req) begin ok = 1'b0; return; end
    idx0 = rd_ctrl_idx; mode0 = rd_ctrl_dpram_mode;
    if (scramble) begin
      wvb_not_empty = N_CHAN'($urandom);
      dpram_mode_in = ~dpram_mode_in;
    end
    for (int f = 0; f < 8; f++) begin
      w = 0;
      while (!dpram_ready && w < 100) begin @(negedge clk); w++; end
      if (!dpram_ready) begin ok = 1'b0; return; end
      if (drop_en && f == 0) en = 1'b0;
      nfill++;
      if (dpram_len !== rd_ctrl_len || rd_ctrl_idx !== idx0 ||
          rd_ctrl_dpram_mode !== mode0 || rd_ctrl_req !== 1'b1) bad++;
      more_now = rd_ctrl_more;
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        if (dpram_ready !== 1'b1 || dpram_len !== rd_ctrl_len) bad++;
        if (scramble) dpram_mode_in = ~dpram_mode_in;
      end
      next_len = 16'($urandom);
      dpram_done = 1'b1; @(negedge clk); dpram_done = 1'b0;
      if (!more_now) break;
    end
    w = 0;
    while (n_evt == evt0 && w < 20) begin @(negedge clk); w++; end
    if (n_evt == evt0) ok = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if ({rd_ctrl_req, dpram_ready, rd_ctrl_dpram_mode} !== 3'b000) begin
      fails++; $display("FAIL reset_flags: got %b required 000",
                        {rd_ctrl_req, dpram_ready, rd_ctrl_dpram_mode});
    end
    tests++;
    if (rd_ctrl_idx !== 8'd0 || dpram_len !== 16'd0) begin
      fails++; $display("FAIL reset_idx_len: got idx=%0d len=%h required 0/0",
                        rd_ctrl_idx, dpram_len);
    end
    tests++;
    if (n_evt !== 16'd0 || n_fill !== 16'd0) begin
      fails++; $display("FAIL reset_counters: got %0d/%0d required 0/0", n_evt, n_fill);
    end
  endtask

  task automatic test_single();
    int w;
    @(negedge clk);
    wvb_not_empty = N_CHAN'(24'h000004); en = 1'b1;
    ctl_delay = 2; next_len = 16'h0030; ack_base = ctl_acks; more_left = 0;
    @(negedge clk);
    tests++;
    if (rd_ctrl_req !== 1'b1 || rd_ctrl_idx !== 8'd2) begin
      fails++; $display("FAIL single_grant: got req=%b idx=%0d required 1/2",
                        rd_ctrl_req, rd_ctrl_idx);
    end
    wvb_not_empty = '0;
    w = 0;
    while (!dpram_ready && w < 50) begin @(negedge clk); w++; end
    tests++;
    if (dpram_ready !== 1'b1 || dpram_len !== 16'h0030 || n_fill !== 16'd1) begin
      fails++; $display("FAIL single_fill: got rdy=%b len=%h nfill=%0d required 1/0030/1",
                        dpram_ready, dpram_len, n_fill);
    end
    dpram_done = 1'b1; @(negedge clk); dpram_done = 1'b0;
    tests++;
    if (rd_ctrl_req !== 1'b0 || dpram_ready !== 1'b0 || dpram_len !== 16'h0) begin
      fails++; $display("FAIL single_release: got req=%b rdy=%b len=%h required 0/0/0000",
                        rd_ctrl_req, dpram_ready, dpram_len);
    end
    w = 0;
    while (n_evt == 16'd0 && w < 20) begin @(negedge clk); w++; end
    tests++;
    if (n_evt !== 16'd1 || n_fill !== 16'd1 || rd_ctrl_req !== 1'b0) begin
      fails++; $display("FAIL single_done: got nevt=%0d nfill=%0d req=%b required 1/1/0",
                        n_evt, n_fill, rd_ctrl_req);
    end
    m_ptr = 2; m_evt = 1; m_fill = 1;
  endtask

  task automatic test_rr();
    int          order [6];
    bit          ok;
    logic [7:0]  idx0;
    logic        mode0;
    int          nfill, bad;
    order = '{0, 5, 23, 0, 5, 23};
    apply_reset();
    en = 1'b1; ctl_delay = 1; more_left = 0;
    wvb_not_empty = N_CHAN'((1 << 0) | (1 << 5) | (1 << 23));
    for (int e = 0; e < 6; e++) begin
      serve_event(1'b0, 1'b0, ok, idx0, mode0, nfill, bad);
      tests++;
      if (!ok || int'(idx0) != order[e] || bad != 0) begin
        fails++; $display("FAIL rr_order[%0d]: got ok=%0d idx=%0d bad=%0d required 1/%0d/0",
                          e, ok, idx0, bad, order[e]);
      end
    end
    wvb_not_empty = '0;
    m_ptr = 23; m_evt = 6; m_fill = 6;
    tests++;
    if (n_evt !== 16'(m_evt) || n_fill !== 16'(m_fill)) begin
      fails++; $display("FAIL rr_counters: got %0d/%0d required %0d/%0d",
                        n_evt, n_fill, m_evt, m_fill);
    end
  endtask

  task automatic test_mode1();
    bit         ok;
    logic [7:0] idx0;
    logic       mode0;
    int         nfill, bad, exp;
    wvb_not_empty = N_CHAN'(1 << 7); dpram_mode_in = 1'b1; en = 1'b1;
    ctl_delay = 1; more_left = 2;
    exp = rr_pick(wvb_not_empty, m_ptr);
    serve_event(1'b1, 1'b0, ok, idx0, mode0, nfill, bad);
    wvb_not_empty = '0;
    m_ptr = exp; m_evt += 1; m_fill += 3;
    tests++;
    if (!ok || int'(idx0) != exp || mode0 !== 1'b1 || nfill != 3 || bad != 0) begin
      fails++; $display("FAIL mode1_cont: got ok=%0d idx=%0d mode=%b fills=%0d bad=%0d required 1/%0d/1/3/0",
                        ok, idx0, mode0, nfill, bad, exp);
    end
    tests++;
    if (n_evt !== 16'(m_evt) || n_fill !== 16'(m_fill)) begin
      fails++; $display("FAIL mode1_counters: got %0d/%0d required %0d/%0d",
                        n_evt, n_fill, m_evt, m_fill);
    end
  endtask

  task automatic test_done_in_req();
    int w;
    logic [15:0] evt0;
    wvb_not_empty = N_CHAN'(1 << 12); en = 1'b1;
    ctl_delay = 6; more_left = 0; ack_base = ctl_acks; next_len = 16'h1234;
    evt0 = n_evt;
    w = 0;
    while (!rd_ctrl_req && w < 50) begin @(negedge clk); w++; end
    wvb_not_empty = '0;
    dpram_done = 1'b1; @(negedge clk); dpram_done = 1'b0;
    tests++;
    if (dpram_ready !== 1'b0 || rd_ctrl_req !== 1'b1) begin
      fails++; $display("FAIL done_in_req: got rdy=%b req=%b required 0/1",
                        dpram_ready, rd_ctrl_req);
    end
    w = 0;
    while (!dpram_ready && w < 50) begin @(negedge clk); w++; end
    tests++;
    if (dpram_ready !== 1'b1 || dpram_len !== 16'h1234 || n_fill !== 16'(m_fill + 1)) begin
      fails++; $display("FAIL done_in_req_fill: got rdy=%b len=%h nfill=%0d required 1/1234/%0d",
                        dpram_ready, dpram_len, n_fill, m_fill + 1);
    end
    dpram_done = 1'b1; @(negedge clk); dpram_done = 1'b0;
    w = 0;
    while (n_evt == evt0 && w < 20) begin @(negedge clk); w++; end
    m_ptr = 12; m_evt += 1; m_fill += 1;
    tests++;
    if (n_evt !== 16'(m_evt)) begin
      fails++; $display("FAIL done_in_req_evt: got %0d required %0d", n_evt, m_evt);
    end
  endtask

  task automatic test_en_drop();
    bit         ok;
    logic [7:0] idx0;
    logic       mode0;
    int         nfill, bad, exp, stray;
    wvb_not_empty = N_CHAN'(1 << 3); en = 1'b1; ctl_delay = 0; more_left = 1;
    exp = rr_pick(wvb_not_empty, m_ptr);
    serve_event(1'b0, 1'b1, ok, idx0, mode0, nfill, bad);
    m_ptr = exp; m_evt += 1; m_fill += 2;
    tests++;
    if (!ok || int'(idx0) != exp || nfill != 2 || bad != 0) begin
      fails++; $display("FAIL en_drop_event: got ok=%0d idx=%0d fills=%0d bad=%0d required 1/%0d/2/0",
                        ok, idx0, nfill, bad, exp);
    end
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (rd_ctrl_req !== 1'b0) stray++;
    end
    tests++;
    if (stray != 0 || n_evt !== 16'(m_evt) || n_fill !== 16'(m_fill)) begin
      fails++; $display("FAIL en_drop_idle: got req_cycles=%0d nevt=%0d nfill=%0d required 0/%0d/%0d",
                        stray, n_evt, n_fill, m_evt, m_fill);
    end
    wvb_not_empty = '0; en = 1'b1;
  endtask

  task automatic test_rst_mid();
    bit         ok;
    logic [7:0] idx0;
    logic       mode0;
    int         nfill, bad, w;
    wvb_not_empty = N_CHAN'(1 << 9); en = 1'b1; ctl_delay = 1; more_left = 0;
    ack_base = ctl_acks;
    w = 0;
    while (!dpram_ready && w < 50) begin @(negedge clk); w++; end
    tests++;
    if (dpram_ready !== 1'b1) begin
      fails++; $display("FAIL rst_mid_setup: got rdy=%b required 1", dpram_ready);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (rd_ctrl_req !== 1'b0 || dpram_ready !== 1'b0 || dpram_len !== 16'h0) begin
      fails++; $display("FAIL rst_mid_outputs: got req=%b rdy=%b len=%h required 0/0/0000",
                        rd_ctrl_req, dpram_ready, dpram_len);
    end
    tests++;
    if (n_evt !== 16'd0 || n_fill !== 16'd0) begin
      fails++; $display("FAIL rst_mid_counters: got %0d/%0d required 0/0", n_evt, n_fill);
    end
    @(negedge clk);
    rst = 1'b0;
    m_ptr = N_CHAN - 1; m_evt = 0; m_fill = 0;
    wvb_not_empty = N_CHAN'((1 << 9) | 1);
    serve_event(1'b0, 1'b0, ok, idx0, mode0, nfill, bad);
    wvb_not_empty = '0;
    m_ptr = 0; m_evt = 1; m_fill = 1;
    tests++;
    if (!ok || idx0 !== 8'd0 || n_evt !== 16'd1 || n_fill !== 16'd1) begin
      fails++; $display("FAIL rst_mid_first: got ok=%0d idx=%0d nevt=%0d nfill=%0d required 1/0/1/1",
                        ok, idx0, n_evt, n_fill);
    end
  endtask

  task automatic test_random();
    bit          ok;
    logic [7:0]  idx0;
    logic        mode0, mode_set;
    int          nfill, bad, exp, nmore;
    logic [N_CHAN-1:0] mask;
    en = 1'b1;
    for (int e = 0; e < 40; e++) begin
      mask = N_CHAN'($urandom);
      if (mask == '0) mask[$urandom_range(0, N_CHAN - 1)] = 1'b1;
      mode_set = 1'($urandom);
      nmore = $urandom_range(0, 2);
      ctl_delay = $urandom_range(0, 4);
      more_left = nmore;
      wvb_not_empty = mask; dpram_mode_in = mode_set;
      exp = rr_pick(mask, m_ptr);
      serve_event(1'b1, 1'b0, ok, idx0, mode0, nfill, bad);
      m_ptr = exp; m_evt += 1; m_fill += nmore + 1;
      tests++;
      if (!ok || int'(idx0) != exp || mode0 !== mode_set) begin
        fails++; $display("FAIL rand_grant[%0d]: got ok=%0d idx=%0d mode=%b required 1/%0d/%b",
                          e, ok, idx0, mode0, exp, mode_set);
      end
      tests++;
      if (nfill != nmore + 1 || bad != 0) begin
        fails++; $display("FAIL rand_fills[%0d]: got fills=%0d bad=%0d required %0d/0",
                          e, nfill, bad, nmore + 1);
      end
      tests++;
      if (n_evt !== 16'(m_evt) || n_fill !== 16'(m_fill)) begin
        fails++; $display("FAIL rand_counters[%0d]: got %0d/%0d required %0d/%0d",
                          e, n_evt, n_fill, m_evt, m_fill);
      end
    end
    wvb_not_empty = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_mode1();
    test_done_in_req();
    test_en_drop();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
